// File: rtl/xor_keystream_descrambler.sv
// Stream descrambler: XORs each accepted word with an LFSR keystream, reseeding every FRAME_LEN words.
// Optional macro DESCR_BYPASS_EN adds a per-word bypass input that passes data through unchanged.
module xor_keystream_descrambler #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] SEED      = 32'hFFFFFFFF,
    parameter logic [WIDTH-1:0] POLY      = 32'h04C11DB7,
    parameter int               FRAME_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_load,
    input  logic [WIDTH-1:0] seed_in,
`ifdef DESCR_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_end,
    output logic [15:0]      word_cnt,
    output logic             state_dbg
);

    // Handshake rules (both sides): a transfer happens on a rising edge where
    // valid && ready; valid never depends on ready, and the producer holds data
    // stable while valid && !ready. in_ready is combinational from out_valid,
    // out_ready and sync_load.

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] key_nxt;
    logic [15:0]      cnt_nxt;
    logic             accept;
    logic             last_word;
    logic             byp;

`ifdef DESCR_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    assign state_dbg = state;
    assign last_word = (word_cnt == LAST_IDX);

    always_comb begin
        state_nxt = state;
        in_ready  = !sync_load && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        key_nxt   = key;
        cnt_nxt   = word_cnt;

        case (state)
            RUN:     if (sync_load) state_nxt = LOAD;
            LOAD:    state_nxt = sync_load ? LOAD : RUN;
            default: state_nxt = RUN;
        endcase

        // sync_load takes priority and blocks the input, so it never races an accept.
        if (sync_load) begin
            key_nxt = seed_in;
            cnt_nxt = '0;
        end else if (accept) begin
            if (last_word) begin
                key_nxt = SEED;
                cnt_nxt = '0;
            end else begin
                key_nxt = {key[WIDTH-2:0], ^(key & POLY)};
                cnt_nxt = word_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            key      <= SEED;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            key      <= key_nxt;
            word_cnt <= cnt_nxt;
        end
    end

    // Single output register; an accept in the same cycle as a drain overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_end <= 1'b0;
        end else if (accept) begin
            out_data  <= byp ? in_data : (in_data ^ key);
            out_valid <= 1'b1;
            frame_end <= last_word;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            frame_end <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_keystream_descrambler.sv
// Bench for xor_keystream_descrambler (FRAME_LEN=4): vector table, directed corner sequences,
// and randomized traffic against a transaction-level keystream model.
module tb_xor_keystream_descrambler;

    localparam int          W         = 32;
    localparam int          FRAME_LEN = 4;
    localparam logic [31:0] SEED      = 32'hFFFFFFFF;
    localparam logic [31:0] POLY      = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_load;
    logic [31:0] seed_in;
    logic        bypass_in;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_end;
    logic [15:0] word_cnt;
    logic        state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    // Scoreboard: {frame_end, data} of words expected on the output.
    logic [W:0]  exp_q[$];
    logic [31:0] m_key;
    int          m_cnt;

    typedef struct {
        logic        rst_before;
        logic [31:0] din;
        logic [31:0] exp_out;
        logic [15:0] exp_cnt;
        logic        exp_fe;
    } vec_t;

    vec_t vecs[8];

    xor_keystream_descrambler #(
        .WIDTH(W), .SEED(SEED), .POLY(POLY), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sync_load(sync_load),
        .seed_in(seed_in),
`ifdef DESCR_BYPASS_EN
        .bypass(bypass_in),
`endif
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_end(frame_end),
        .word_cnt(word_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] k);
        int fb;
        fb = $countones(k & POLY) % 2;
        return (k << 1) | 32'(fb);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_key = SEED;
        m_cnt = 0;
    endtask

    task automatic idle_inputs();
        sync_load = 1'b0;
        seed_in   = '0;
        bypass_in = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // Leaves the bench at posedge+1 with the DUT out of reset.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // Offer one word with out_ready=1 and return at posedge+1 after it is taken.
    task automatic send_word(input logic [31:0] d, input logic byp);
        in_data   = d;
        bypass_in = byp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // First words after reset, then a five-word frame wrap on zeros.
        vecs[0] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 16'd1, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 16'd2, 1'b0};
        vecs[2] = '{1'b0, 32'h00000003, 32'hFFFFFFFE, 16'd3, 1'b0};
        vecs[3] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 16'd1, 1'b0};
        vecs[4] = '{1'b0, 32'h00000000, 32'hFFFFFFFE, 16'd2, 1'b0};
        vecs[5] = '{1'b0, 32'h00000000, 32'hFFFFFFFD, 16'd3, 1'b0};
        vecs[6] = '{1'b0, 32'h00000000, 32'hFFFFFFFB, 16'd0, 1'b1};
        vecs[7] = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 16'd1, 1'b0};

        do_reset();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset word_cnt", 32'(word_cnt), 32'd0);
        chk("reset frame_end", 32'(frame_end), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst_before) do_reset();
            send_word(vecs[i].din, 1'b0);
            chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_out);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d word_cnt", i), 32'(word_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d frame_end", i), 32'(frame_end), 32'(vecs[i].exp_fe));
        end

        // Backpressure: three stalled clocks with the next word pending.
        do_reset();
        send_word(32'h00000000, 1'b0);
        out_ready = 1'b0;
        in_data   = 32'hFFFFFFFF;
        in_valid  = 1'b1;
        #1;
        chk("bp in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp in_ready hold", 32'(in_ready), 32'd0);
            chk("bp out_data hold", out_data, 32'hFFFFFFFF);
            chk("bp out_valid hold", 32'(out_valid), 32'd1);
            chk("bp word_cnt hold", 32'(word_cnt), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp release out_data", out_data, 32'h00000001);
        chk("bp release word_cnt", 32'(word_cnt), 32'd2);

        // sync_load colliding with in_valid: the input must be refused.
        do_reset();
        sync_load = 1'b1;
        seed_in   = 32'h12345678;
        in_data   = 32'hDEADBEEF;
        in_valid  = 1'b1;
        #1;
        chk("sync in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        sync_load = 1'b0;
        in_valid  = 1'b0;
        chk("sync no accept", 32'(out_valid), 32'd0);
        chk("sync word_cnt", 32'(word_cnt), 32'd0);
        send_word(32'h00000000, 1'b0);
        chk("sync first out", out_data, 32'h12345678);
        chk("sync first cnt", 32'(word_cnt), 32'd1);

        // Asynchronous reset between clock edges with a word held on the output.
        do_reset();
        send_word(32'h00000000, 1'b0);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async out_data", out_data, 32'h0);
        chk("async word_cnt", 32'(word_cnt), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h00000000, 1'b0);
        chk("async restart out", out_data, 32'hFFFFFFFF);

`ifdef DESCR_BYPASS_EN
        do_reset();
        send_word(32'hAAAAAAAA, 1'b1);
        chk("bypass word1", out_data, 32'hAAAAAAAA);
        send_word(32'h00000000, 1'b0);
        chk("bypass word2", out_data, 32'hFFFFFFFE);
        chk("bypass cnt", 32'(word_cnt), 32'd2);
`endif

        // Randomized traffic against the transaction model.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic       m_ready;
            logic       drain;
            logic [W:0] head;
            sync_load = ($urandom_range(0, 39) == 0);
            seed_in   = $urandom;
            in_data   = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef DESCR_BYPASS_EN
            bypass_in = ($urandom_range(0, 4) == 0);
`endif
            #1;
            m_ready = !sync_load && (exp_q.size() == 0 || out_ready);
            chk("rnd in_ready", 32'(in_ready), 32'(m_ready));
            chk("rnd out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                chk("rnd out_data", out_data, head[W-1:0]);
                chk("rnd frame_end", 32'(frame_end), 32'(head[W]));
            end
            drain = (exp_q.size() != 0) && out_ready;
            if (drain) void'(exp_q.pop_front());
            if (sync_load) begin
                m_key = seed_in;
                m_cnt = 0;
            end else if (in_valid && m_ready) begin
                exp_q.push_back({m_cnt == FRAME_LEN - 1,
                                 bypass_in ? in_data : (in_data ^ m_key)});
                if (m_cnt == FRAME_LEN - 1) begin
                    m_key = SEED;
                    m_cnt = 0;
                end else begin
                    m_key = lfsr_next(m_key);
                    m_cnt++;
                end
            end
            @(posedge clk);
            #1;
            chk("rnd word_cnt", 32'(word_cnt), 32'(m_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
